// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: two-flop input synchroniser, mid-bit sampling,
// one-cycle valid strobe per good byte and one-cycle strobe per stop-bit violation.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic       i_RX_SERIAL,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_BYTE,
    output logic       o_RX_FRAME_ERR,
    output logic       o_RX_BUSY
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e           state;
    logic             rx_s1;
    logic             rx_s2;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;

    // Synchroniser resets to the idle-high line level so reset release never looks like a start bit.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= i_RX_SERIAL;
            rx_s2 <= rx_s1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state          <= StIdle;
            clk_cnt        <= '0;
            bit_idx        <= 3'd0;
            rx_shift       <= 8'h00;
            o_RX_DV        <= 1'b0;
            o_RX_BYTE      <= 8'h00;
            o_RX_FRAME_ERR <= 1'b0;
            o_RX_BUSY      <= 1'b0;
        end else begin
            o_RX_DV        <= 1'b0;
            o_RX_FRAME_ERR <= 1'b0;
            unique case (state)
                StIdle: begin
                    clk_cnt <= '0;
                    bit_idx <= 3'd0;
                    if (!rx_s2) begin
                        state     <= StStart;
                        o_RX_BUSY <= 1'b1;
                    end
                end
                StStart: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        if (!rx_s2) begin
                            state <= StData;
                        end else begin
                            state     <= StIdle;
                            o_RX_BUSY <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt           <= '0;
                        rx_shift[bit_idx] <= rx_s2;
                        if (bit_idx == 3'd7) begin
                            state <= StStop;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s2) begin
                            o_RX_BYTE <= rx_shift;
                            o_RX_DV   <= 1'b1;
                            o_RX_BUSY <= 1'b0;
                            state     <= StIdle;
                        end else begin
                            o_RX_FRAME_ERR <= 1'b1;
                            state          <= StWaitHigh;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                StWaitHigh: begin
                    // Break guard: a held-low line reports one error, not one per frame time.
                    clk_cnt <= '0;
                    if (rx_s2) begin
                        state     <= StIdle;
                        o_RX_BUSY <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    clk_cnt   <= '0;
                    o_RX_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link, the counterpart of `UART_TX` on the other end of the line. Format is 8N1, LSB first. The block synchronises the asynchronous `i_RX_SERIAL` line, samples each bit at mid-bit, and presents each received byte with a one-cycle valid strobe. Stop-bit violations are flagged and not delivered as data. In loopback it consumes `o_TX_SERIAL` directly.

## Interface
- `CLKS_PER_BIT`, default 87: `i_CLK` cycles per serial bit (10 MHz / 115200). Legal range is ≥ 4.
- `i_CLK`  in  1  system clock.
- `i_RST_N`  in  1  asynchronous, active-low reset.
- `i_RX_SERIAL`  in  1  serial line; idles high; asynchronous to `i_CLK`.
- `o_RX_DV`  out  1  one-cycle pulse: `o_RX_BYTE` holds a newly received, correctly framed byte.
- `o_RX_BYTE`  out  8  last good byte; holds its value between frames.
- `o_RX_FRAME_ERR`  out  1  one-cycle pulse: stop bit sampled low.
- `o_RX_BUSY`  out  1  high in every state except IDLE.

## Operation
- Input path: two-flop synchroniser (`rx_s1` → `rx_s2`). Both flops reset to 1. All decisions use `rx_s2`.
- Counter `clk_cnt` has width `$clog2(CLKS_PER_BIT)` and counts 0..CLKS_PER_BIT-1. It is cleared on every state change.
- `bit_idx` is 3 bits wide.
- Shift register `rx_shift` is 8 bits wide. Received bit *n* is written to `rx_shift[n]`.
- States:
  - IDLE: `clk_cnt` = 0, `bit_idx` = 0. When `rx_s2` = 0, go to START.
  - START: count up to HALF = (CLKS_PER_BIT-1)/2 (integer division). At `clk_cnt` == HALF:
    - if `rx_s2` = 0, go to DATA;
    - else (glitch) go to IDLE with no outputs.
  - DATA: at `clk_cnt` == CLKS_PER_BIT-1, sample `rx_s2` into `rx_shift[bit_idx]`.
    - If `bit_idx` == 7, go to STOP.
    - Else increment `bit_idx` and stay in DATA.
  - STOP: at `clk_cnt` == CLKS_PER_BIT-1, sample `rx_s2`.
    - If 1: load `o_RX_BYTE` ← `rx_shift`, pulse `o_RX_DV`, go to IDLE.
    - If 0: pulse `o_RX_FRAME_ERR`, leave `o_RX_BYTE` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s2` = 1, then go to IDLE. This state is a break guard, so a held-low line produces exactly one error.
- Outputs are registered. `o_RX_DV` and `o_RX_FRAME_ERR` are never high in the same cycle.
- Back-to-back frames: the next start bit may begin immediately after the stop bit. The receiver is back in IDLE half a bit before the stop-bit end edge, so no frame is missed.

## Timing
- Reset values (asserted asynchronously; deasserted on a synchronous basis to `i_CLK`):
  - state = IDLE;
  - `o_RX_DV` = 0, `o_RX_FRAME_ERR` = 0, `o_RX_BUSY` = 0;
  - `o_RX_BYTE` = 8'h00;
  - `rx_shift` = 0, counters = 0;
  - synchroniser flops = 1.
- Reset mid-frame aborts the frame immediately. No DV or error pulse follows. The receiver re-arms on the next falling edge after release.
- Let E be the first `i_CLK` edge at which `i_RX_SERIAL` = 0 is captured in `rx_s1`.
  - `rx_s2` = 0 at E+1.
  - START is entered at E+2.
  - START lasts HALF+1 cycles.
  - Each DATA bit lasts CLKS_PER_BIT cycles.
  - STOP lasts CLKS_PER_BIT cycles.
- `o_RX_DV` / `o_RX_FRAME_ERR` are high for the single cycle after the last STOP cycle: edge E+2+(HALF+1)+9·CLKS_PER_BIT.
- `o_RX_BYTE` changes on that same edge and is stable from then on.
- `o_RX_BUSY` rises at E+2. It falls on the same edge as the DV pulse, or on the IDLE entry after WAIT_HIGH / glitch reject.
- Glitch rejection: a low pulse shorter than about HALF cycles at the synchroniser output is rejected.

## Test plan
Bench conditions: 100 ns clock, CLKS_PER_BIT = 8 unless noted.
- Loopback `UART_TX` → `uart_rx`, same CLKS_PER_BIT; send 8'h05 → exactly one `o_RX_DV` pulse with `o_RX_BYTE` = 8'h05; no `o_RX_FRAME_ERR`; `o_RX_BUSY` low afterwards.
- Bench-driven frames 8'hA5, 8'h00, 8'hFF back-to-back (zero idle between stop and next start) → three DV pulses, bytes in order. DV edge matches the Timing formula exactly, i.e. E+2+4+72.
- Low glitch of 2 cycles on idle line → no DV, no error. `o_RX_BUSY` high for at most HALF+1 = 4 cycles, then IDLE. A following valid 8'h3C is received correctly.
- Frame 8'h81 with stop bit driven 0, line returned high 3 bits later:
  - one `o_RX_FRAME_ERR` pulse;
  - `o_RX_BYTE` keeps the previous value;
  - `o_RX_BUSY` falls 2 cycles after the line rises.
  - A following 8'h42 is received correctly.
- Line held low for 40 bit times (break) → exactly one `o_RX_FRAME_ERR`, no DV. Receiver is idle 2 cycles after release.
- Assert `i_RST_N` low during bit 4 of 8'hC3 → all outputs are at reset values immediately. No pulses after release. The next frame, 8'h5A, is received correctly. Repeat the 8'h05 loopback with CLKS_PER_BIT = 87 → byte 8'h05.
